alu_issue_queue: RTL

Buffered issue stage upstream of the 32-bit combinational `Alu` (operands `A`, `B`, 3-bit `ALUControl`, output `result`). It accepts operation commands over a valid/ready handshake and holds them in a DEPTH-entry FIFO. It presents the head command to `Alu`, then registers `Alu`'s `result` into an output register with its own valid/ready handshake. This gives the datapath a one-cycle registered ALU stage with back-pressure and up to one result per cycle.

---
 rtl/alu_issue_queue.sv | 100 ++++++++++
 1 files changed

// File: rtl/alu_issue_queue.sv
`default_nettype none
// ============================================================================
// Module   : alu_issue_queue
// Brief    : Command FIFO feeding an external combinational Alu, with a
//            registered, back-pressured result stage.
// Revision : 1.0 - initial release
// ============================================================================
module alu_issue_queue #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 32
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [WIDTH-1:0]         in_A,
    input  logic [WIDTH-1:0]         in_B,
    input  logic [2:0]               in_ALUControl,
    output logic [WIDTH-1:0]         alu_A,
    output logic [WIDTH-1:0]         alu_B,
    output logic [2:0]               alu_ALUControl,
    input  logic [WIDTH-1:0]         alu_result,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [WIDTH-1:0]         out_result,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] c_full = CW'(DEPTH);
    localparam logic [CW-1:0] c_one  = CW'(1);
    localparam logic [AW-1:0] c_inc  = AW'(1);

    logic [WIDTH-1:0] r_mem_a  [DEPTH];
    logic [WIDTH-1:0] r_mem_b  [DEPTH];
    logic [2:0]       r_mem_op [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             r_out_valid;
    logic [WIDTH-1:0] r_out_result;

    logic w_empty;
    logic w_push;
    logic w_issue;

    // in_ready depends on occupancy alone, so out_ready never reaches it.
    assign w_empty  = (r_count == '0);
    assign in_ready = (r_count != c_full);
    assign w_push   = in_valid && in_ready;
    assign w_issue  = !w_empty && (!r_out_valid || out_ready);

    assign alu_A          = w_empty ? '0 : r_mem_a[r_rd_ptr];
    assign alu_B          = w_empty ? '0 : r_mem_b[r_rd_ptr];
    assign alu_ALUControl = w_empty ? 3'b000 : r_mem_op[r_rd_ptr];

    assign out_valid  = r_out_valid;
    assign out_result = r_out_result;
    assign count      = r_count;

    // Storage is left unreset; the empty-gating on alu_* hides stale entries.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_a[r_wr_ptr]  <= in_A;
            r_mem_b[r_wr_ptr]  <= in_B;
            r_mem_op[r_wr_ptr] <= in_ALUControl;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_count      <= '0;
            r_out_valid  <= 1'b0;
            r_out_result <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_inc;
            end
            if (w_issue) begin
                r_rd_ptr <= r_rd_ptr + c_inc;
            end
            if (w_push && !w_issue) begin
                r_count <= r_count + c_one;
            end else if (!w_push && w_issue) begin
                r_count <= r_count - c_one;
            end
            if (w_issue) begin
                r_out_result <= alu_result;
                r_out_valid  <= 1'b1;
            end else if (out_ready) begin
                r_out_valid  <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire
